// File: rtl/shim_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shim_trigger_sequencer
// Description : Program buffer and playback engine. Software loads a list of
//               32-bit trigger commands and starts playback with a repeat
//               count. The list is offered to the trigger core as a FIFO read
//               stream, looped the requested number of times. A stop request
//               ends playback with a single CANCEL word so the core aborts
//               cleanly.
// Revision    : 1.0 - initial release
// ============================================================================
module shim_trigger_sequencer #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] CANCEL_WORD = 32'hE000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  prog_wr_en,
  input  logic [31:0]           prog_wr_data,
  input  logic                  prog_clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           repeat_count,
  output logic [31:0]           cmd_word,
  output logic                  cmd_buf_empty,
  input  logic                  cmd_word_rd_en,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  running,
  output logic                  done,
  output logic [15:0]           passes_left,
  output logic                  wr_error,
  output logic                  underflow
);

  localparam int                    c_DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   c_LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_CANCEL = 2'd2
  } state_t;

  state_t                r_state;
  logic [31:0]           r_mem [c_DEPTH_N];
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_prog_len;
  logic [15:0]           r_passes_left;
  logic                  r_infinite;
  logic                  r_done;
  logic                  r_wr_error;
  logic                  r_underflow;

  logic w_idle;
  logic w_wr_accept;
  logic w_wr_reject;
  logic w_start_ok;
  logic w_last_word;
  logic w_more_passes;

  assign w_idle        = (r_state == S_IDLE);
  // Clear has priority over a same-cycle write; a write lost to a clear is
  // not an error.
  assign w_wr_accept   = w_idle && prog_wr_en && !prog_clear && (r_prog_len != c_DEPTH);
  assign w_wr_reject   = prog_wr_en && (!w_idle || (!prog_clear && (r_prog_len == c_DEPTH)));
  // A start coinciding with a clear is refused so playback never runs on an
  // empty program.
  assign w_start_ok    = w_idle && start && !stop && !prog_clear && (r_prog_len != c_LEN_ZERO);
  assign w_last_word   = ({1'b0, r_rd_ptr} == (r_prog_len - c_LEN_ONE));
  assign w_more_passes = r_infinite || (r_passes_left > 16'd1);

  // Program buffer write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && w_wr_accept) begin
      r_mem[r_prog_len[ADDR_WIDTH-1:0]] <= prog_wr_data;
    end
  end

  // Playback state machine, pointers, pass counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_rd_ptr      <= '0;
      r_prog_len    <= '0;
      r_passes_left <= '0;
      r_infinite    <= 1'b0;
      r_done        <= 1'b0;
      r_wr_error    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wr_reject) begin
        r_wr_error <= 1'b1;
      end
      if (cmd_word_rd_en && w_idle) begin
        r_underflow <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (prog_clear) begin
            r_prog_len <= '0;
            r_done     <= 1'b0;
          end else if (w_wr_accept) begin
            r_prog_len <= r_prog_len + c_LEN_ONE;
          end
          if (w_start_ok) begin
            r_rd_ptr      <= '0;
            r_passes_left <= repeat_count;
            r_infinite    <= (repeat_count == 16'd0);
            r_done        <= 1'b0;
            r_state       <= S_RUN;
          end
        end

        S_RUN: begin
          // Stop discards the pointer/pass effect of a same-cycle read.
          if (stop) begin
            r_state <= S_CANCEL;
          end else if (cmd_word_rd_en) begin
            if (!w_last_word) begin
              r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end else if (w_more_passes) begin
              r_rd_ptr <= '0;
              if (!r_infinite) begin
                r_passes_left <= r_passes_left - 16'd1;
              end
            end else begin
              r_rd_ptr      <= '0;
              r_passes_left <= '0;
              r_done        <= 1'b1;
              r_state       <= S_IDLE;
            end
          end
        end

        S_CANCEL: begin
          if (cmd_word_rd_en) begin
            r_rd_ptr      <= '0;
            r_passes_left <= '0;
            r_infinite    <= 1'b0;
            r_done        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Word presented to the trigger core for the current state.
  always_comb begin
    cmd_word = 32'd0;
    case (r_state)
      S_RUN:    cmd_word = r_mem[r_rd_ptr];
      S_CANCEL: cmd_word = CANCEL_WORD;
      default:  cmd_word = 32'd0;
    endcase
  end

  assign cmd_buf_empty = w_idle;
  assign running       = !w_idle;
  assign prog_len      = r_prog_len;
  assign done          = r_done;
  assign passes_left   = r_passes_left;
  assign wr_error      = r_wr_error;
  assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_shim_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shim_trigger_sequencer
// Description : Scoreboard bench for shim_trigger_sequencer. A list-level
//               model (program queue, consumed-word count, repeat count)
//               predicts every consumed word and the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shim_trigger_sequencer;

  localparam int          AW     = 2;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] CANCEL = 32'hE000_0000;

  logic        clk;
  logic        resetn;
  logic        prog_wr_en;
  logic [31:0] prog_wr_data;
  logic        prog_clear;
  logic        start;
  logic        stop;
  logic [15:0] repeat_count;
  logic [31:0] cmd_word;
  logic        cmd_buf_empty;
  logic        cmd_word_rd_en;
  logic [AW:0] prog_len;
  logic        running;
  logic        done;
  logic [15:0] passes_left;
  logic        wr_error;
  logic        underflow;

  shim_trigger_sequencer #(
    .ADDR_WIDTH (AW),
    .CANCEL_WORD(CANCEL)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .prog_wr_en    (prog_wr_en),
    .prog_wr_data  (prog_wr_data),
    .prog_clear    (prog_clear),
    .start         (start),
    .stop          (stop),
    .repeat_count  (repeat_count),
    .cmd_word      (cmd_word),
    .cmd_buf_empty (cmd_buf_empty),
    .cmd_word_rd_en(cmd_word_rd_en),
    .prog_len      (prog_len),
    .running       (running),
    .done          (done),
    .passes_left   (passes_left),
    .wr_error      (wr_error),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 playing, 2 cancel pending.
  logic [31:0] m_prog[$];
  logic [31:0] exp_q[$];
  int          m_mode;
  int          m_k;
  int          m_reps;
  bit          m_done;
  bit          m_wr_err;
  bit          m_under;
  logic [15:0] m_cancel_passes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_passes();
    if (m_mode == 1) begin
      if (m_reps == 0) return 16'd0;
      return 16'(m_reps - (m_k / m_prog.size()));
    end
    if (m_mode == 2) return m_cancel_passes;
    return 16'd0;
  endfunction

  task automatic check_status();
    check("running",       32'(running),       32'(m_mode != 0));
    check("cmd_buf_empty", 32'(cmd_buf_empty), 32'(m_mode == 0));
    check("prog_len",      32'(prog_len),      32'(m_prog.size()));
    check("done",          32'(done),          32'(m_done));
    check("wr_error",      32'(wr_error),      32'(m_wr_err));
    check("underflow",     32'(underflow),     32'(m_under));
    check("passes_left",   32'(passes_left),   32'(m_passes()));
    if (m_mode == 0) check("cmd_word_idle", cmd_word, 32'd0);
    if (m_mode == 2) check("cmd_word_cancel", cmd_word, CANCEL);
  endtask

  // One clock of stimulus: drive inputs, advance the model, check after edge.
  task automatic cycle(input bit wr, input logic [31:0] wd, input bit clr,
                       input bit st, input bit sp, input bit rd, input logic [15:0] rc);
    int sz0;
    prog_wr_en     = wr;
    prog_wr_data   = wd;
    prog_clear     = clr;
    start          = st;
    stop           = sp;
    cmd_word_rd_en = rd;
    repeat_count   = rc;
    sz0 = m_prog.size();
    case (m_mode)
      0: begin
        if (rd) m_under = 1'b1;
        if (clr) begin
          m_prog.delete();
          m_done = 1'b0;
        end else if (wr) begin
          if (m_prog.size() < DEPTH) m_prog.push_back(wd);
          else m_wr_err = 1'b1;
        end
        if (st && !sp && !clr && sz0 > 0) begin
          m_mode = 1;
          m_k    = 0;
          m_reps = int'(rc);
          m_done = 1'b0;
        end
      end
      1: begin
        if (wr) m_wr_err = 1'b1;
        if (rd) exp_q.push_back(m_prog[m_k % m_prog.size()]);
        if (sp) begin
          m_cancel_passes = m_passes();
          m_mode = 2;
        end else if (rd) begin
          m_k++;
          if (m_reps != 0 && m_k == m_prog.size() * m_reps) begin
            m_mode = 0;
            m_done = 1'b1;
          end
        end
      end
      default: begin
        if (wr) m_wr_err = 1'b1;
        if (rd) begin
          exp_q.push_back(CANCEL);
          m_mode = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    prog_wr_en     = 1'b0;
    prog_wr_data   = 32'd0;
    prog_clear     = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    cmd_word_rd_en = 1'b0;
    repeat_count   = 16'd0;
    m_prog.delete();
    m_mode   = 0;
    m_k      = 0;
    m_reps   = 0;
    m_done   = 1'b0;
    m_wr_err = 1'b0;
    m_under  = 1'b0;
    @(posedge clk);
    #1;
    check_status();
    resetn = 1'b1;
  endtask

  task automatic wr_word(input logic [31:0] w);
    cycle(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic go(input logic [15:0] rc);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, rc);
  endtask

  task automatic rd1();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
  endtask

  task automatic clear();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  // Monitor: every word the core actually consumes is matched against the
  // scoreboard queue.
  always @(negedge clk) begin
    if (resetn && cmd_word_rd_en && !cmd_buf_empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", cmd_word, 32'hDEAD_BEEF);
      end else begin
        check("cmd_word", cmd_word, exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    // Three words, two passes, continuous reads.
    wr_word(32'hA000_000A);
    wr_word(32'hB000_000B);
    wr_word(32'hC000_000C);
    go(16'd2);
    repeat (6) rd1();

    // Infinite mode, stop together with the 11th read, then drain CANCEL.
    clear();
    wr_word(32'h1111_0001);
    wr_word(32'h2222_0002);
    go(16'd0);
    repeat (10) rd1();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    rd1();
    go(16'd1);
    rd1();
    rd1();

    // Overfill: fifth write rejected, first four retained.
    clear();
    for (int i = 0; i < 5; i++) wr_word(32'h5000_0000 + 32'(i));
    go(16'd1);
    repeat (4) rd1();

    // Empty start ignored, read while empty flags underflow.
    clear();
    go(16'd3);
    rd1();

    // Writes, clear and start during playback are ignored.
    do_reset();
    wr_word(32'h0000_0A01);
    wr_word(32'h0000_0A02);
    wr_word(32'h0000_0A03);
    go(16'd1);
    rd1();
    wr_word(32'hFFFF_FFFF);
    clear();
    go(16'd5);
    rd1();
    rd1();

    // Single-word program repeated, and start+stop in idle.
    clear();
    wr_word(32'h7777_0007);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    go(16'd3);
    repeat (3) rd1();

    // Reset mid-pass with words remaining: no CANCEL, program lost.
    rd1();
    clear();
    wr_word(32'h0000_00C1);
    wr_word(32'h0000_00C2);
    go(16'd2);
    rd1();
    do_reset();
    rd1();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_mode == 0) begin
        if (r < 30)      wr_word($urandom());
        else if (r < 34) clear();
        else if (r < 46) go(16'($urandom_range(0, 3)));
        else if (r < 49) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
        else if (r < 52) rd1();
        else if (r < 54) do_reset();
        else cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      end else begin
        if (r == 0) begin
          do_reset();
        end else begin
          cycle($urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 3) != 0, 16'($urandom_range(0, 3)));
        end
      end
    end

    repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
